oe_sort_engine: RTL

- Parametrised odd-even transposition sorter; successor to the 4×8-bit bubble sorter.
- Generalised in element count N and element width W.
- Adds run-time ascending/descending mode, valid/ready handshakes on both sides, asynchronous reset and deterministic latency.
- Sits between a vector producer and consumer in the sorting datapath; one vector is in flight at a time.

---
 rtl/sort_pkg.sv | 19 +
 rtl/cmp_swap.sv | 18 +
 rtl/oe_sort_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Phase counter must hold values 0..n.
  function automatic int phase_w(input int n);
    return (n < 2) ? 2 : $clog2(n + 1);
  endfunction

  function automatic int elem_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Unsigned compare-exchange cell; lo feeds the lower array index.
module cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         descend,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  // Equal elements never swap, keeping the exchange stable.
  assign swapped = descend ? (a < b) : (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/oe_sort_engine.sv
// Odd-even transposition sorter, one vector in flight, N phases per vector.
// Optional early termination on two clean phases: define OE_SORT_EARLY_EXIT_EN.
module oe_sort_engine
  import sort_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] data_in,
  input  logic           descend,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] data_out,
  output logic           busy
);

  localparam int PW  = phase_w(N);
  localparam int NE  = N / 2;
  localparam int NO  = (N - 1) / 2;
  localparam int NOW = (NO > 0) ? NO : 1;

  state_t         state;
  logic [PW-1:0]  phase;
  logic           desc_q;
  logic [N*W-1:0] arr;
  logic [N*W-1:0] next_arr;
  logic           phase_swap;
  logic           last_phase;

  wire [N*W-1:0]  even_arr;
  wire [N*W-1:0]  odd_arr;
  wire [NE-1:0]   even_sw;
  wire [NOW-1:0]  odd_sw;

  // Even network: pairs (0,1),(2,3),...
  for (genvar j = 0; j < NE; j++) begin : g_even
    cmp_swap #(.W(W)) u_cs (
      .a       (arr[elem_lsb(2*j, W) +: W]),
      .b       (arr[elem_lsb(2*j+1, W) +: W]),
      .descend (desc_q),
      .lo      (even_arr[elem_lsb(2*j, W) +: W]),
      .hi      (even_arr[elem_lsb(2*j+1, W) +: W]),
      .swapped (even_sw[j])
    );
  end
  if (N % 2 == 1) begin : g_even_tail
    assign even_arr[elem_lsb(N-1, W) +: W] = arr[elem_lsb(N-1, W) +: W];
  end

  // Odd network: pairs (1,2),(3,4),..., element 0 always passes through.
  for (genvar j = 0; j < NO; j++) begin : g_odd
    cmp_swap #(.W(W)) u_cs (
      .a       (arr[elem_lsb(2*j+1, W) +: W]),
      .b       (arr[elem_lsb(2*j+2, W) +: W]),
      .descend (desc_q),
      .lo      (odd_arr[elem_lsb(2*j+1, W) +: W]),
      .hi      (odd_arr[elem_lsb(2*j+2, W) +: W]),
      .swapped (odd_sw[j])
    );
  end
  assign odd_arr[W-1:0] = arr[W-1:0];
  if (N % 2 == 0) begin : g_odd_tail
    assign odd_arr[elem_lsb(N-1, W) +: W] = arr[elem_lsb(N-1, W) +: W];
  end
  if (NO == 0) begin : g_odd_none
    assign odd_sw = '0;
  end

  always_comb begin
    next_arr   = phase[0] ? odd_arr : even_arr;
    phase_swap = phase[0] ? (|odd_sw) : (|even_sw);
  end

`ifdef OE_SORT_EARLY_EXIT_EN
  logic prev_clean;

  // Two consecutive swap-free phases mean every adjacent pair is ordered.
  assign last_phase = (phase == PW'(N - 1)) ||
                      ((phase != '0) && !phase_swap && prev_clean);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_clean <= 1'b0;
    end else if (state == ST_SORT) begin
      prev_clean <= !phase_swap;
    end else begin
      prev_clean <= 1'b0;
    end
  end
`else
  logic unused_phase_swap;

  assign unused_phase_swap = phase_swap;
  assign last_phase        = (phase == PW'(N - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= '0;
      desc_q    <= 1'b0;
      arr       <= '0;
      data_out  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            arr      <= data_in;
            desc_q   <= descend;
            phase    <= '0;
            state    <= ST_SORT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SORT: begin
          arr   <= next_arr;
          phase <= phase + PW'(1);
          if (last_phase) begin
            data_out  <= next_arr;
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
